mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   Sequencer and arbiter for the TLB->cache->memory hierarchy. Two requesters share one hierarchy:
//   port 0 is instruction fetch, port 1 is data. Requests are accepted one at a time.
//   Each request is taken through translate + cache lookup, then victim write-back and refill
//   on a miss. The result is returned as a one-cycle response pulse.
//   Memory latency is variable and signalled by mem_ack.
//   The block also keeps saturating hit/miss counters.
// PARAMETERS
//   ADDR_W     10   virtual/physical byte address width
//   DATA_W     64   word width on requester and cache ports
//   BLK_W      128  block width on memory bus
//   TIMEOUT    255  max cycles waiting on mem_ack before error abort
//   CNT_W      16   width of hit/miss counters
// PORTS
//   clk             in   1       clock
//   rst_n           in   1       synchronous active-low reset
//   reqN_valid      in   1       N=0,1: request pending
//   reqN_isRead     in   1       1=read, 0=write
//   reqN_addr       in   ADDR_W  virtual address
//   reqN_wdata      in   DATA_W  write data
//   reqN_ready      out  1       1-cycle accept pulse; request latched that cycle
//   respN_valid     out  1       1-cycle completion pulse
//   respN_rdata     out  DATA_W  read data, valid with respN_valid
//   respN_err       out  1       memory timeout, valid with respN_valid
//   cache_en        out  1       cache performs lookup/access this cycle
//   cache_isRead    out  1       access type
//   cache_addr      out  ADDR_W  virtual address to TLB+cache
//   cache_wdata     out  DATA_W  write word
//   cache_rdata     in   DATA_W  read word, valid same cycle as cache_en
//   cache_hit       in   1       hit, valid same cycle as cache_en
//   cache_vDirty    in   1       victim line dirty, valid on miss
//   cache_vAddr     in   ADDR_W  victim block physical address
//   cache_vData     in   BLK_W   victim block data
//   cache_pAddr     in   ADDR_W  translated physical address of request
//   cache_fill      out  1       1-cycle pulse: write cache_fillData into line, clear dirty
//   cache_fillData  out  BLK_W   refill block
//   mem_req         out  1       memory transaction active; held until mem_ack
//   mem_we          out  1       1=write-back, 0=refill read
//   mem_addr        out  ADDR_W  block-aligned address ([1:0]=0)
//   mem_wdata       out  BLK_W   write-back block
//   mem_rdata       in   BLK_W   refill block, valid with mem_ack
//   mem_ack         in   1       1-cycle completion from memory
//   hitCount        out  CNT_W   saturating hit counter
//   missCount       out  CNT_W   saturating miss counter
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=0 (port 0 favoured first); counters=0; all other outputs 0.
//   FSM: IDLE, LOOKUP, WB, FILL, REPLAY, RESP.
//   - IDLE: if any reqN_valid, grant one, pulse reqN_ready, latch request and owner -> LOOKUP.
//     Both valid: round-robin; the pointer flips to the non-granted port after every grant.
//   - LOOKUP: cache_en=1 with latched request (write hit commits here).
//     hit -> hitCount++ -> RESP; data captured from cache_rdata.
//     miss -> missCount++ and latch cache_pAddr.
//     Also latch cache_vAddr/cache_vData when cache_vDirty. Then -> WB if vDirty, else FILL.
//   - WB: mem_req=1, mem_we=1, mem_addr={vAddr[9:2],2'b0}, mem_wdata=vData. mem_ack -> FILL.
//   - FILL: mem_req=1, mem_we=0, mem_addr={pAddr[9:2],2'b0}.
//     mem_ack -> capture mem_rdata, pulse cache_fill next cycle -> REPLAY.
//   - REPLAY: cache_en=1 with latched request (write-allocate; write commits here), must hit;
//     counters untouched -> RESP.
//   - RESP: respN_valid=1 for owner only, rdata held from last access -> IDLE. Earliest next accept is the cycle after RESP.
//   Latency: hit = 3 cycles accept->resp (IDLE, LOOKUP, RESP);
//     miss adds memory wait(s) + 2 (fill pulse, REPLAY).
//   mem_ack outside WB/FILL is ignored. mem_req stays stable (addr/we/wdata constant) until ack.
//   Timeout: wait counter clears on entry to WB/FILL. If it reaches TIMEOUT without ack:
//     abort -> RESP with respN_err=1, rdata=0, no cache_fill.
//   Counters saturate at all-ones and never wrap.
//   A requester deasserting valid after ready is irrelevant: the request is already latched.
//   A requester is never granted twice before its response.
//   reset mid-transaction: immediate return to IDLE, mem_req drops, no resp pulse, no fill.
// STRUCTURE
//   Shared package: state enum, ADDR_W/DATA_W/BLK_W defaults, block-align offset width (2).
//   Sub-module rr_arbiter2: 2-way round-robin grant with pointer update on accept.
//   Remainder (FSM, request latch, timeout counter, perf counters) lives in this module.
// TESTING
//   1 Read hit port1 addr 0x04C, cache_hit=1, rdata=0xDEAD -> ready@T, resp1_valid@T+2 rdata 0xDEAD, hitCount=1.
//   2 Clean read miss, ack after 5 cycles, mem_rdata=0xA5..A5 -> one mem read at 0x04C, one fill pulse, REPLAY, resp; missCount=1.
//   3 Dirty write miss, vAddr=0x120 -> WB at 0x120 (we=1) then FILL at pAddr block, REPLAY write, resp0_valid, no err.
//   4 Both ports valid continuously -> grants alternate 0,1,0,1; no port granted twice before its resp.
//   5 mem_ack withheld -> abort after TIMEOUT cycles, resp err=1, no cache_fill; next request served normally.
//   6 rst_n low during WB -> next cycle IDLE, mem_req=0, counters 0; hitCount saturation at 0xFFFF holds.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: default widths,
// block-offset width and the sequencer state encoding.
package mem_access_ctrl_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  localparam int BLK_W_DEF  = 128;
  localparam int OFS_W      = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_REPLAY,
    S_RESP
  } state_t;
endpackage

// File: rtl/mem_access_ctrl_rr_arbiter2.sv
// Two-way round-robin grant; on every accepted grant the preference
// moves to the port that was not granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // gnt[0] set means port 0 won, so port 1 is preferred next time
  always_ff @(posedge clk) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= gnt[0];
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the TLB->cache->memory path: one request at a time
// through lookup, optional victim write-back, refill and replay.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BLK_W   = BLK_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_isRead,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_isRead,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              cache_en,
  output logic              cache_isRead,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  input  logic              cache_vDirty,
  input  logic [ADDR_W-1:0] cache_vAddr,
  input  logic [BLK_W-1:0]  cache_vData,
  input  logic [ADDR_W-1:0] cache_pAddr,
  output logic              cache_fill,
  output logic [BLK_W-1:0]  cache_fillData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFS_W) - 1);

  state_t            state, state_nx;
  logic [1:0]        gnt;
  logic              accept, owner, lat_rd, fill_pend, err, wait_last;
  logic [ADDR_W-1:0] lat_addr, p_addr, v_addr;
  logic [DATA_W-1:0] lat_wdata, rdata;
  logic [BLK_W-1:0]  v_data, fill_data;
  logic [TW-1:0]     wait_cnt;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .accept(accept),
    .gnt   (gnt)
  );

  assign accept     = rst_n && (state == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && gnt[0];
  assign req1_ready = accept && gnt[1];
  assign wait_last  = (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FILL spends one extra cycle (fill_pend) pulsing cache_fill after the ack
  always_comb begin
    state_nx   = state;
    cache_en   = 1'b0;
    cache_fill = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      S_IDLE:   if (accept) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        cache_en = 1'b1;
        if (cache_hit)         state_nx = S_RESP;
        else if (cache_vDirty) state_nx = S_WB;
        else                   state_nx = S_FILL;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = v_addr & BLK_MASK;
        mem_wdata = v_data;
        if (mem_ack)        state_nx = S_FILL;
        else if (wait_last) state_nx = S_RESP;
      end
      S_FILL: begin
        if (fill_pend) begin
          cache_fill = 1'b1;
          state_nx   = S_REPLAY;
        end else begin
          mem_req  = 1'b1;
          mem_addr = p_addr & BLK_MASK;
          if (!mem_ack && wait_last) state_nx = S_RESP;
        end
      end
      S_REPLAY: begin
        cache_en = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      lat_rd    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p_addr    <= '0;
      v_addr    <= '0;
      v_data    <= '0;
      fill_data <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      fill_pend <= 1'b0;
      wait_cnt  <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          owner     <= gnt[1];
          lat_rd    <= gnt[1] ? req1_isRead : req0_isRead;
          lat_addr  <= gnt[1] ? req1_addr   : req0_addr;
          lat_wdata <= gnt[1] ? req1_wdata  : req0_wdata;
          err       <= 1'b0;
          fill_pend <= 1'b0;
        end
        S_LOOKUP: begin
          wait_cnt <= '0;
          if (cache_hit) begin
            rdata <= cache_rdata;
            if (hitCount != '1) hitCount <= hitCount + 1'b1;
          end else begin
            if (missCount != '1) missCount <= missCount + 1'b1;
            p_addr <= cache_pAddr;
            if (cache_vDirty) begin
              v_addr <= cache_vAddr;
              v_data <= cache_vData;
            end
          end
        end
        S_WB: begin
          if (mem_ack) wait_cnt <= '0;
          else if (wait_last) begin
            err   <= 1'b1;
            rdata <= '0;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        S_FILL: begin
          if (fill_pend) fill_pend <= 1'b0;
          else if (mem_ack) begin
            fill_data <= mem_rdata;
            fill_pend <= 1'b1;
          end else if (wait_last) begin
            err   <= 1'b1;
            rdata <= '0;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        S_REPLAY: rdata <= cache_rdata;
        default: ;
      endcase
    end
  end

  assign cache_isRead   = lat_rd;
  assign cache_addr     = lat_addr;
  assign cache_wdata    = lat_wdata;
  assign cache_fillData = fill_data;

  assign resp0_valid = (state == S_RESP) && !owner;
  assign resp1_valid = (state == S_RESP) && owner;
  assign resp0_rdata = resp0_valid ? rdata : '0;
  assign resp1_rdata = resp1_valid ? rdata : '0;
  assign resp0_err   = resp0_valid && err;
  assign resp1_err   = resp1_valid && err;
endmodule
